register_arbiter: RTL

Round-robin write arbiter for the shared 8-bit enable-load register. Up to four requesters compete to load the register. The arbiter grants one requester at a time and drives the register's ENA/DATA inputs for exactly one clock. It then acknowledges the winner with the register's new contents. It sits directly in front of the register and is the only block permitted to drive its ENA and DATA.

---
 rtl/register_arbiter_pkg.sv | 23 ++
 rtl/register_arbiter_rr_pick.sv | 41 ++++
 rtl/register_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/register_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// register_arbiter_pkg
// Shared definitions for the round-robin write arbiter that sits in front of
// the 8-bit enable-load register: default sizes and FSM state encoding.
// ---------------------------------------------------------------------------
package register_arbiter_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;

   // Code 2'b11 is unused and recovers to IDLE on the next clock.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_ACK  = 2'b10
   } state_t;

   // Width of a requester index / round-robin pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/register_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// register_arbiter_rr_pick
// Combinational round-robin priority picker. The search starts at index
// i_ptr and wraps modulo NREQ; the first set request bit wins.
//
// Ports
//   i_req     request vector
//   i_ptr     index with highest priority this round
//   o_onehot  one-hot winner (all zero when nothing is requested)
//   o_idx     winner index
//   o_valid   at least one request is set
// ---------------------------------------------------------------------------
module register_arbiter_rr_pick
   import register_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int PTR_W = ptr_width(NREQ_DEF)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_onehot,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_valid
);

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         logic [PTR_W-1:0] w_pos;
         w_pos = PTR_W'((int'(i_ptr) + k) % NREQ);
         if (!o_valid && i_req[w_pos]) begin
            o_valid         = 1'b1;
            o_idx           = w_pos;
            o_onehot[w_pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/register_arbiter.sv
// ---------------------------------------------------------------------------
// register_arbiter
// Round-robin write arbiter for the shared enable-load register. One
// requester at a time is granted; the arbiter drives the register's load
// enable/data for exactly one clock and then acknowledges the winner with
// the register's new contents. Each transaction takes three cycles.
//
// State table
//   state | meaning
//   IDLE  | waiting for any request; outputs quiet, DATA/RDATA hold
//   LOAD  | grant latched, ENA=1, DATA drives the register
//   ACK   | register holds new value, ACK pulses, RDATA=R
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_req    per-requester write request (level)
//   i_wdata  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   i_r      current register contents
//   o_ena    register load enable
//   o_data   register load data
//   o_gnt    one-hot grant, held through LOAD and ACK
//   o_ack    one-hot completion pulse
//   o_rdata  register value returned with ACK
//   o_busy   high in any state other than IDLE
// ---------------------------------------------------------------------------
module register_arbiter
   import register_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*WIDTH-1:0] i_wdata,
   input  logic [WIDTH-1:0]      i_r,
   output logic                  o_ena,
   output logic [WIDTH-1:0]      o_data,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_ack,
   output logic [WIDTH-1:0]      o_rdata,
   output logic                  o_busy
);

   localparam int PTR_W = ptr_width(NREQ);

   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [NREQ-1:0]    r_gnt;
   logic [NREQ-1:0]    r_ack;
   logic [WIDTH-1:0]   r_data;
   logic [WIDTH-1:0]   r_rdata;
   logic               r_ena;
   logic               r_busy;

   logic [NREQ-1:0]    w_onehot;
   logic [PTR_W-1:0]   w_idx;
   logic               w_valid;
   logic [PTR_W-1:0]   w_ptr_next;
   logic [WIDTH-1:0]   w_wdata_win;

   register_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_valid  (w_valid)
   );

   // Pointer moves one past the winner; the last index wraps to 0.
   assign w_ptr_next = (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + PTR_W'(1);

   // One-hot AND-OR mux of the winner's write data.
   always_comb begin
      w_wdata_win = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_wdata_win = w_wdata_win | (i_wdata[k*WIDTH +: WIDTH] & {WIDTH{w_onehot[k]}});
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_data  <= '0;
         r_rdata <= '0;
         r_ena   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_state <= ST_LOAD;
                  r_gnt   <= w_onehot;
                  r_data  <= w_wdata_win;
                  r_ena   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_ptr   <= w_ptr_next;
               end
            end
            ST_LOAD: begin
               r_state <= ST_ACK;
               r_ena   <= 1'b0;
               r_ack   <= r_gnt;
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
               r_ack   <= '0;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               // Keep the returned value visible after the ACK cycle.
               r_rdata <= i_r;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ena   <= 1'b0;
               r_gnt   <= '0;
               r_ack   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ena   = r_ena;
   assign o_data  = r_data;
   assign o_gnt   = r_gnt;
   assign o_ack   = r_ack;
   assign o_busy  = r_busy;
   // The register only updates on the LOAD->ACK edge, so during ACK its
   // outputs already hold the freshly loaded value; return them directly.
   assign o_rdata = (r_state == ST_ACK) ? i_r : r_rdata;

endmodule
